// File: rtl/score_keeper_pkg.sv
// Shared constants and helpers for the score keeper: game-state encodings,
// BCD point values and the add-sequencer state type.
package score_keeper_pkg;

    localparam logic [1:0] ST_PRE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_DEL = 2'd2;
    localparam logic [1:0] ST_END = 2'd3;

    localparam int LINES_PER_LEVEL_DEF = 10;
    localparam int MAX_LEVEL_DEF       = 9;

    localparam logic [23:0] PTS_1 = 24'h000040;
    localparam logic [23:0] PTS_2 = 24'h000100;
    localparam logic [23:0] PTS_3 = 24'h000300;
    localparam logic [23:0] PTS_4 = 24'h001200;

    typedef enum logic {
        FSM_IDLE,
        FSM_ADD
    } fsm_t;

    function automatic logic [23:0] points_for(input logic [2:0] n);
        case (n)
            3'd1:    return PTS_1;
            3'd2:    return PTS_2;
            3'd3:    return PTS_3;
            3'd4:    return PTS_4;
            default: return 24'h000000;
        endcase
    endfunction

    // The gameplay stage can report up to 7; only four rows can ever clear at once.
    function automatic logic [2:0] clamp_get(input logic [2:0] g);
        return (g > 3'd4) ? 3'd4 : g;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_add6.sv
// Combinational 6-digit packed-BCD adder, digit-serial ripple with +6 correction.
module bcd_add6 (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [23:0] sum,
    output logic        cout
);

    logic [4:0] digit;
    logic       carry;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        digit = 5'd0;
        carry = 1'b0;
        sum   = 24'h000000;
        for (int i = 0; i < 6; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
            if (digit > 5'd9) begin
                digit = digit + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = digit[3:0];
        end
        cout = carry;
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: captures line clears from the gameplay stage and accumulates
// BCD score (repeated add, level+1 cycles), BCD line total and level.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int LINES_PER_LEVEL = LINES_PER_LEVEL_DEF,
    parameter int MAX_LEVEL       = MAX_LEVEL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [2:0]  get,
    output logic [23:0] score,
    output logic [11:0] lines,
    output logic [3:0]  level,
    output logic        busy,
    output logic        level_up
);

    logic [1:0]  prev_state;
    logic [2:0]  pend;
    logic [2:0]  cmt_n;
    logic        commit_req;
    fsm_t        fsm_q;
    fsm_t        fsm_d;
    logic [23:0] base;
    logic [4:0]  rep;
    logic [4:0]  lines_in_level;
    logic [4:0]  lil_sum;

    logic [23:0] score_sum;
    logic        score_cout;
    logic [23:0] lines_sum;
    logic        lines_cout;
    logic        lines_sat;

    logic clear_req;
    logic do_commit;
    logic do_add;

    bcd_add6 u_score_add (
        .a    (score),
        .b    (base),
        .sum  (score_sum),
        .cout (score_cout)
    );

    // Lines reuse the same adder with the upper three digits held at zero.
    bcd_add6 u_lines_add (
        .a    ({12'h000, lines}),
        .b    ({21'h000000, cmt_n}),
        .sum  (lines_sum),
        .cout (lines_cout)
    );

    assign lines_sat = lines_cout || (lines_sum[23:12] != 12'h000);
    assign lil_sum   = lines_in_level + {2'b00, cmt_n};
    assign clear_req = (state == ST_PRE);
    assign do_commit = (fsm_q == FSM_IDLE) && commit_req && !clear_req && (state != ST_END);
    assign do_add    = (fsm_q == FSM_ADD) && !clear_req;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= FSM_IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (clear_req) begin
            fsm_d = FSM_IDLE;
        end else if (fsm_q == FSM_IDLE) begin
            if (do_commit) fsm_d = FSM_ADD;
        end else begin
            if (score_cout || rep == 5'd1) fsm_d = FSM_IDLE;
        end
    end

    always_comb begin
        busy = (fsm_q == FSM_ADD);
    end

    // Capture keeps running during an add so a clear in a new DEL phase is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= ST_PRE;
            pend       <= 3'd0;
            cmt_n      <= 3'd0;
            commit_req <= 1'b0;
        end else begin
            prev_state <= state;
            if (clear_req) begin
                pend       <= 3'd0;
                commit_req <= 1'b0;
            end else begin
                if (do_commit) commit_req <= 1'b0;
                if (state == ST_DEL) begin
                    if (clamp_get(get) > pend) pend <= clamp_get(get);
                end else if (prev_state == ST_DEL && pend != 3'd0) begin
                    commit_req <= 1'b1;
                    cmt_n      <= pend;
                    pend       <= 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score          <= 24'h000000;
            lines          <= 12'h000;
            level          <= 4'd0;
            lines_in_level <= 5'd0;
            level_up       <= 1'b0;
            base           <= 24'h000000;
            rep            <= 5'd0;
        end else begin
            level_up <= 1'b0;
            if (clear_req) begin
                score          <= 24'h000000;
                lines          <= 12'h000;
                level          <= 4'd0;
                lines_in_level <= 5'd0;
            end else begin
                if (do_commit) begin
                    base  <= points_for(cmt_n);
                    rep   <= {1'b0, level} + 5'd1;
                    lines <= lines_sat ? 12'h999 : lines_sum[11:0];
                    if (lil_sum >= 5'(LINES_PER_LEVEL)) begin
                        if (level < 4'(MAX_LEVEL)) begin
                            level          <= level + 4'd1;
                            lines_in_level <= lil_sum - 5'(LINES_PER_LEVEL);
                            level_up       <= 1'b1;
                        end else begin
                            lines_in_level <= 5'(LINES_PER_LEVEL - 1);
                        end
                    end else begin
                        lines_in_level <= lil_sum;
                    end
                end
                // A carry out of the top digit pins the score and ends the add early.
                if (do_add) begin
                    if (score_cout) begin
                        score <= 24'h999999;
                    end else begin
                        score <= score_sum;
                        rep   <= rep - 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed clears feed a decimal reference
// model into a queue; a monitor pops an entry each time busy falls.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic [2:0]  get;
    logic [23:0] score;
    logic [11:0] lines;
    logic [3:0]  level;
    logic        busy;
    logic        level_up;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] score;
        logic [11:0] lines;
        logic [3:0]  level;
        int          busy_len;
        int          lu;
        int          lil;
    } exp_t;

    exp_t exp_q[$];

    int m_score, m_lines, m_level, m_lil;

    score_keeper dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .get      (get),
        .score    (score),
        .lines    (lines),
        .level    (level),
        .busy     (busy),
        .level_up (level_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = 24'h0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int pts_dec(input int n);
        case (n)
            1:       return 40;
            2:       return 100;
            3:       return 300;
            default: return 1200;
        endcase
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_lines = 0;
        m_level = 0;
        m_lil   = 0;
    endtask

    // Decimal reference for one committed clear; pushes the state expected when busy falls.
    task automatic model_commit(input int g);
        exp_t e;
        int   n, s, cyc;
        n   = (g > 4) ? 4 : g;
        s   = m_score;
        cyc = 0;
        for (int i = 0; i <= m_level; i++) begin
            cyc++;
            s += pts_dec(n);
            if (s > 999999) begin
                s = 999999;
                break;
            end
        end
        m_score = s;
        m_lines = (m_lines + n > 999) ? 999 : m_lines + n;
        m_lil  += n;
        e.lu    = 0;
        if (m_lil >= 10) begin
            if (m_level < 9) begin
                m_level++;
                m_lil -= 10;
                e.lu = 1;
            end else begin
                m_lil = 9;
            end
        end
        e.score    = to_bcd(m_score);
        e.lines    = to_bcd(m_lines)[11:0];
        e.level    = 4'(m_level);
        e.busy_len = cyc;
        e.lil      = m_lil;
        exp_q.push_back(e);
    endtask

    task automatic do_clear(input int g);
        int guard;
        model_commit(g);
        state = ST_DEL;
        get   = 3'(g);
        repeat (3) tick();
        state = ST_RUN;
        get   = 3'd0;
        repeat (2) tick();
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        check("busy_bounded", 32'(guard < 20), 32'd1);
        tick();
    endtask

    // Monitor: counts busy/level_up cycles and checks the outputs when busy falls.
    initial begin
        int   busy_len = 0;
        int   lu_cnt   = 0;
        logic busy_d   = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_len++;
            if (level_up === 1'b1) lu_cnt++;
            if (busy === 1'b0 && busy_d === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_add", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("score", 32'(score), 32'(e.score));
                    check("lines", 32'(lines), 32'(e.lines));
                    check("level", 32'(level), 32'(e.level));
                    check("busy_cycles", 32'(busy_len), 32'(e.busy_len));
                    check("level_up_pulses", 32'(lu_cnt), 32'(e.lu));
                    check("lines_in_level", 32'(dut.lines_in_level), 32'(e.lil));
                end
                busy_len = 0;
                lu_cnt   = 0;
            end
            busy_d = busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t e;
        rst   = 1'b1;
        state = ST_PRE;
        get   = 3'd0;
        model_reset();
        repeat (2) tick();
        check("rst_score", 32'(score), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        state = ST_RUN;
        tick();

        // Level 0 single: one busy cycle, 000040 points.
        do_clear(1);
        check("first_score", 32'(score), 32'h000040);
        check("first_lines", 32'(lines), 32'h001);

        // Mid-cycle reset pulse clears outputs without waiting for an edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_score", 32'(score), 32'h0);
        check("async_lines", 32'(lines), 32'h0);
        check("async_level", 32'(level), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        state = ST_PRE;
        repeat (2) tick();
        state = ST_RUN;
        tick();
        model_reset();
        check("pre_score", 32'(score), 32'h0);

        // Ten singles from level 0: tenth clear advances to level 1.
        for (int i = 0; i < 10; i++) do_clear(1);
        check("ten_lines", 32'(lines), 32'h010);
        check("ten_level", 32'(level), 32'd1);
        check("ten_score", 32'(score), 32'h000400);
        check("ten_lil", 32'(dut.lines_in_level), 32'd0);

        do_clear(4);
        do_clear(4);
        do_clear(2);
        check("l2_level", 32'(level), 32'd2);
        check("l2_score", 32'(score), 32'h005400);

        // Level 2 tetris: three adds of 001200.
        do_clear(4);
        check("l2_tetris_score", 32'(score), 32'h009000);
        check("l2_tetris_lines", 32'(lines), 32'h024);

        // get=7 clamps to four lines.
        do_clear(7);
        check("clamp_score", 32'(score), 32'h012600);
        check("clamp_lines", 32'(lines), 32'h028);

        do_clear(4);
        do_clear(4);
        do_clear(4);
        check("l4_level", 32'(level), 32'd4);
        check("l4_score", 32'(score), 32'h025800);

        // PRE during ADD aborts the add and clears everything.
        e.score    = 24'h0;
        e.lines    = 12'h0;
        e.level    = 4'd0;
        e.busy_len = 1;
        e.lu       = 0;
        e.lil      = 0;
        exp_q.push_back(e);
        state = ST_DEL;
        get   = 3'd4;
        repeat (3) tick();
        state = ST_RUN;
        get   = 3'd0;
        repeat (2) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        state = ST_PRE;
        tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_score", 32'(score), 32'h0);
        check("abort_lines", 32'(lines), 32'h0);
        tick();
        state = ST_RUN;
        model_reset();
        repeat (2) tick();

        for (int i = 0; i < 10; i++) do_clear(4);
        check("rebuild_level", 32'(level), 32'd4);

        // A DEL phase inside a 5-cycle add is committed once the add finishes.
        model_commit(4);
        model_commit(2);
        state = ST_DEL;
        get   = 3'd4;
        repeat (3) tick();
        state = ST_RUN;
        get   = 3'd0;
        repeat (2) tick();
        state = ST_DEL;
        get   = 3'd2;
        repeat (2) tick();
        state = ST_RUN;
        get   = 3'd0;
        repeat (25) tick();
        check("overlap_lines", 32'(lines), 32'h046);

        // Drive score and lines into saturation, then one more clear.
        for (int k = 0; k < 300 && (m_lines < 999 || m_score < 999999); k++) do_clear(4);
        do_clear(4);
        check("sat_score", 32'(score), 32'h999999);
        check("sat_lines", 32'(lines), 32'h999);
        check("sat_level", 32'(level), 32'd9);
        check("sat_lil", 32'(dut.lines_in_level), 32'd9);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
